talon_stock_ctrl: RTL and testbench

TALON_STOCK_CTRL -- requirements
Module: talon_stock_ctrl

---
 rtl/solitaire_pkg.sv | 17 +
 rtl/card_stack.sv | 73 +++++++
 rtl/talon_stock_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_talon_stock_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/solitaire_pkg.sv
// Shared card definitions and controller state encoding for the solitaire talon logic.
package solitaire_pkg;

  localparam int unsigned CARD_W        = 7;
  localparam int unsigned DEFAULT_DEPTH = 24;

  typedef logic [CARD_W-1:0] card_t;

  localparam card_t NO_CARD = '0;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StRecycle
  } talon_state_e;

endpackage

// File: rtl/card_stack.sv
// LIFO card pile with push, pop, parallel load, clear, registered top-VIS view and size.
module card_stack import solitaire_pkg::*; #(
  parameter int unsigned CARD_W = solitaire_pkg::CARD_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned VIS    = 1,
  localparam int unsigned SZ_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [DEPTH*CARD_W-1:0] load_data,
  input  logic [SZ_W-1:0]         load_size,
  input  logic                    push,
  input  logic [CARD_W-1:0]       push_data,
  input  logic                    pop,
  output logic [VIS*CARD_W-1:0]   view,
  output logic [SZ_W-1:0]         size
);

  logic [CARD_W-1:0]     mem_q [DEPTH];
  logic [CARD_W-1:0]     mem_d [DEPTH];
  logic [SZ_W-1:0]       size_q, size_d;
  logic [VIS*CARD_W-1:0] view_q, view_d;

  always_comb begin
    mem_d  = mem_q;
    size_d = size_q;
    view_d = '0;
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = CARD_W'(NO_CARD);
      size_d = '0;
    end else if (load) begin
      size_d = (32'(load_size) > DEPTH) ? SZ_W'(DEPTH) : load_size;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i] = (i < 32'(size_d)) ? load_data[i*CARD_W +: CARD_W] : CARD_W'(NO_CARD);
      end
    end else if (push && (32'(size_q) < DEPTH)) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i == 32'(size_q)) mem_d[i] = push_data;
      end
      size_d = size_q + 1'b1;
    end else if (pop && (size_q != '0)) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i + 1 == 32'(size_q)) mem_d[i] = CARD_W'(NO_CARD);
      end
      size_d = size_q - 1'b1;
    end

    // View is built from next state so it updates in the same cycle as size.
    for (int unsigned k = 0; k < VIS; k++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i + k + 1 == 32'(size_d)) view_d[k*CARD_W +: CARD_W] = mem_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      size_q <= '0;
      view_q <= '0;
    end else begin
      mem_q  <= mem_d;
      size_q <= size_d;
      view_q <= view_d;
    end
  end

  assign view = view_q;
  assign size = size_q;

endmodule

// File: rtl/talon_stock_ctrl.sv
// Stock/waste talon controller: arbitration, draw/recycle FSM and optional pass limit.
// Define TALON_RECYCLE_LIMIT_EN to cap recycles at MAX_PASSES per deal.
module talon_stock_ctrl import solitaire_pkg::*; #(
  parameter int unsigned CARD_W     = solitaire_pkg::CARD_W,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned DRAW_COUNT = 1,
  parameter int unsigned MAX_PASSES = 3,
  localparam int unsigned SZ_W      = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  input  logic [DEPTH*CARD_W-1:0]      load_pile,
  input  logic [SZ_W-1:0]              load_size,
  input  logic                         draw_req,
  input  logic                         take_req,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [SZ_W-1:0]              stock_size,
  output logic [SZ_W-1:0]              waste_size,
  output logic [DRAW_COUNT*CARD_W-1:0] waste_vis
);

  talon_state_e      state_q, state_d;
  logic [SZ_W-1:0]   cnt_q, cnt_d;
  logic              busy_q, done_q, err_q;
  logic              done_d, err_d;
  logic              stock_load, stock_push, stock_pop;
  logic              waste_clear, waste_push, waste_pop;
  logic [CARD_W-1:0] stock_top;
  logic              recycle_ok;

`ifdef TALON_RECYCLE_LIMIT_EN
  localparam int unsigned PassW = (MAX_PASSES < 1) ? 1 : $clog2(MAX_PASSES + 1);
  logic [PassW-1:0] pass_q, pass_d;

  assign recycle_ok = (32'(pass_q) < MAX_PASSES);

  always_ff @(posedge clk) begin
    if (!rst) pass_q <= '0;
    else      pass_q <= pass_d;
  end
`else
  assign recycle_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    stock_load  = 1'b0;
    stock_push  = 1'b0;
    stock_pop   = 1'b0;
    waste_clear = 1'b0;
    waste_push  = 1'b0;
    waste_pop   = 1'b0;
`ifdef TALON_RECYCLE_LIMIT_EN
    pass_d      = pass_q;
`endif
    if (load_valid) begin
      stock_load  = 1'b1;
      waste_clear = 1'b1;
      state_d     = StIdle;
      cnt_d       = '0;
      if (32'(load_size) > DEPTH) err_d = 1'b1;
      else                        done_d = 1'b1;
`ifdef TALON_RECYCLE_LIMIT_EN
      pass_d      = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (take_req) begin
            if (waste_size != '0) begin
              waste_pop = 1'b1;
              done_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (draw_req) begin
            if (stock_size != '0) begin
              state_d = StDraw;
              cnt_d   = (stock_size < SZ_W'(DRAW_COUNT)) ? stock_size : SZ_W'(DRAW_COUNT);
            end else if (waste_size != '0) begin
              if (recycle_ok) begin
                state_d = StRecycle;
                cnt_d   = waste_size;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StDraw: begin
          stock_pop  = 1'b1;
          waste_push = 1'b1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == SZ_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        StRecycle: begin
          waste_pop  = 1'b1;
          stock_push = 1'b1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == SZ_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
`ifdef TALON_RECYCLE_LIMIT_EN
            pass_d  = pass_q + 1'b1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  card_stack #(
    .CARD_W (CARD_W),
    .DEPTH  (DEPTH),
    .VIS    (1)
  ) u_stock (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .load      (stock_load),
    .load_data (load_pile),
    .load_size (load_size),
    .push      (stock_push),
    .push_data (waste_vis[CARD_W-1:0]),
    .pop       (stock_pop),
    .view      (stock_top),
    .size      (stock_size)
  );

  card_stack #(
    .CARD_W (CARD_W),
    .DEPTH  (DEPTH),
    .VIS    (DRAW_COUNT)
  ) u_waste (
    .clk       (clk),
    .rst       (rst),
    .clear     (waste_clear),
    .load      (1'b0),
    .load_data ('0),
    .load_size ('0),
    .push      (waste_push),
    .push_data (stock_top),
    .pop       (waste_pop),
    .view      (waste_vis),
    .size      (waste_size)
  );

endmodule

// File: tb/tb_talon_stock_ctrl.sv
// Scoreboard bench for talon_stock_ctrl: directed deals, draws, recycles, takes and resets.
module tb_talon_stock_ctrl;

  localparam int CW   = 7;
  localparam int DP   = 24;
  localparam int DC   = 3;
  localparam int MP   = 1;
  localparam int SZ_W = $clog2(DP + 1);

  localparam logic [1:0] EvDone = 2'b10;
  localparam logic [1:0] EvErr  = 2'b01;

  localparam logic [CW-1:0] A = 7'h0A;
  localparam logic [CW-1:0] B = 7'h0B;
  localparam logic [CW-1:0] C = 7'h0C;
  localparam logic [CW-1:0] D = 7'h0D;
  localparam logic [CW-1:0] E = 7'h0E;
  localparam logic [CW-1:0] Z = 7'h00;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_valid = 1'b0;
  logic [DP*CW-1:0]  load_pile = '0;
  logic [SZ_W-1:0]   load_size = '0;
  logic              draw_req = 1'b0;
  logic              take_req = 1'b0;
  logic              busy, done, err;
  logic [SZ_W-1:0]   stock_size, waste_size;
  logic [DC*CW-1:0]  waste_vis;

  typedef struct {
    string            name;
    logic [1:0]       ev;
    int               s;
    int               w;
    logic [DC*CW-1:0] vis;
    int               busy_n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  logic [DP*CW-1:0] deal5, deal_full;

  talon_stock_ctrl #(
    .CARD_W     (CW),
    .DEPTH      (DP),
    .DRAW_COUNT (DC),
    .MAX_PASSES (MP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_pile  (load_pile),
    .load_size  (load_size),
    .draw_req   (draw_req),
    .take_req   (take_req),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .stock_size (stock_size),
    .waste_size (waste_size),
    .waste_vis  (waste_vis)
  );

  always #5 clk = ~clk;

  function automatic logic [DC*CW-1:0] vis3(input logic [CW-1:0] l0, l1, l2);
    return {l2, l1, l0};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input string name, input logic [1:0] ev, input int s, input int w,
                           input logic [DC*CW-1:0] vis, input int bn);
    exp_t x;
    x.name = name; x.ev = ev; x.s = s; x.w = w; x.vis = vis; x.busy_n = bn;
    sb.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 64) begin
      cycle();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic do_load(input string name, input logic [DP*CW-1:0] pile, input int size,
                         input logic [1:0] ev, input int s);
    expect_ev(name, ev, s, 0, '0, 0);
    load_valid = 1'b1;
    load_pile  = pile;
    load_size  = SZ_W'(size);
    cycle();
    load_valid = 1'b0;
  endtask

  task automatic do_req(input string name, input logic tk, input logic dr, input logic [1:0] ev,
                        input int s, input int w, input logic [DC*CW-1:0] vis, input int bn);
    expect_ev(name, ev, s, w, vis, bn);
    take_req = tk;
    draw_req = dr;
    cycle();
    take_req = 1'b0;
    draw_req = 1'b0;
    wait_idle(name);
  endtask

  task automatic check_now(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Monitor: pops one expectation per done/err pulse.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done || err) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got done=%0b err=%0b, required no event", done, err);
          end else begin
            x = sb.pop_front();
            if ({done, err} != x.ev || int'(stock_size) != x.s || int'(waste_size) != x.w ||
                waste_vis != x.vis || busy_cnt != x.busy_n) begin
              errors++;
              $display("FAIL %s: got ev=%b s=%0d w=%0d vis=%h busy=%0d, required ev=%b s=%0d w=%0d vis=%h busy=%0d",
                       x.name, {done, err}, stock_size, waste_size, waste_vis, busy_cnt,
                       x.ev, x.s, x.w, x.vis, x.busy_n);
            end
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    deal5     = '0;
    deal_full = '0;
    for (int i = 0; i < 5; i++) deal5[i*CW +: CW] = CW'(10 + i);
    for (int i = 0; i < DP; i++) deal_full[i*CW +: CW] = CW'(i + 1);

    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    check_now("reset_busy", int'(busy), 0);
    check_now("reset_done_err", int'({done, err}), 0);
    check_now("reset_sizes", int'(stock_size) + int'(waste_size), 0);
    check_now("reset_vis", int'(waste_vis != '0), 0);

    do_load("load5", deal5, 5, EvDone, 5);
    do_req("draw3", 0, 1, EvDone, 2, 3, vis3(C, D, E), 3);
    do_req("draw2", 0, 1, EvDone, 0, 5, vis3(A, B, C), 2);
    do_req("recycle5", 0, 1, EvDone, 5, 0, '0, 5);
    do_req("redraw3", 0, 1, EvDone, 2, 3, vis3(C, D, E), 3);
    do_req("redraw2", 0, 1, EvDone, 0, 5, vis3(A, B, C), 2);
`ifdef TALON_RECYCLE_LIMIT_EN
    do_req("recycle_limit", 0, 1, EvErr, 0, 5, vis3(A, B, C), 0);
`else
    do_req("recycle_again", 0, 1, EvDone, 5, 0, '0, 5);
`endif

    do_load("reload5", deal5, 5, EvDone, 5);
    do_req("draw_for_take", 0, 1, EvDone, 2, 3, vis3(C, D, E), 3);
    do_req("take1", 1, 0, EvDone, 2, 2, vis3(D, E, Z), 0);
    do_req("take_over_draw", 1, 1, EvDone, 2, 1, vis3(E, Z, Z), 0);
    do_req("take_last", 1, 0, EvDone, 2, 0, '0, 0);
    do_req("take_empty", 1, 0, EvErr, 2, 0, '0, 0);
    do_req("draw_short", 0, 1, EvDone, 0, 2, vis3(A, B, Z), 2);
    do_req("recycle2", 0, 1, EvDone, 2, 0, '0, 2);

    do_load("load_clamp", deal_full, 30, EvErr, 24);
    do_req("draw_full", 0, 1, EvDone, 21, 3, vis3(7'd22, 7'd23, 7'd24), 3);

    // Abort a draw after its first busy cycle with a fresh deal.
    draw_req = 1'b1;
    cycle();
    draw_req = 1'b0;
    expect_ev("load_abort", EvDone, 5, 0, '0, 1);
    load_valid = 1'b1;
    load_pile  = deal5;
    load_size  = SZ_W'(5);
    cycle();
    load_valid = 1'b0;
    cycle();

    do_load("load_empty", deal5, 0, EvDone, 0);
    do_req("draw_empty", 0, 1, EvDone, 0, 0, '0, 0);
    do_req("take_both_empty", 1, 0, EvErr, 0, 0, '0, 0);

    // Reset on the second move cycle of a three-card draw; no done may follow.
    do_load("load_pre_rst", deal5, 5, EvDone, 5);
    draw_req = 1'b1;
    cycle();
    draw_req = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check_now("rst_mid_busy", int'(busy), 0);
    check_now("rst_mid_stock", int'(stock_size), 0);
    check_now("rst_mid_waste", int'(waste_size), 0);
    repeat (6) cycle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
    check_now("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
